// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and instruction-fetch request generator for the front of the
// MIPS fetch stage. After reset the unit waits HOLD_CYCLES cycles, then issues
// fetch requests at pc. It advances by INC on each accepted request and follows
// exception flushes and branch redirects, in that priority order. A request
// that has been raised stays raised with a stable address until memory accepts
// it. Redirects that arrive while a request is in flight are parked and applied
// at the accept. A misaligned pc parks the unit in an error state until the
// next flush.
//
// Ports:
//   clk           in   1      clock, all state updates on posedge
//   reset         in   1      synchronous, active-high
//   stall         in   1      pipeline stall; blocks new requests only
//   flush         in   1      exception/ERET redirect (highest priority)
//   flush_pc      in   WIDTH  flush target
//   br_taken      in   1      branch/jump redirect
//   br_target     in   WIDTH  branch target
//   inst_req      out  1      fetch request valid
//   inst_addr     out  WIDTH  fetch address (always equals pc)
//   inst_addr_ok  in   1      memory accepted the request this cycle
//   pc            out  WIDTH  current program counter
//   addr_err      out  1      pc misaligned, fetch suppressed
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'hbfc00000),
    parameter int unsigned      INC          = 4,
    parameter int unsigned      HOLD_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] flush_pc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    output logic [WIDTH-1:0] pc,
    output logic             addr_err
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       hold_cnt_q;
    logic [WIDTH-1:0] pc_q;

    // A request was raised last cycle and memory has not yet taken it.
    logic             req_busy_q;

    // Redirects that arrived while a request was outstanding.
    logic             pend_flush_q;
    logic             pend_br_q;
    logic [WIDTH-1:0] pend_flush_pc_q;
    logic [WIDTH-1:0] pend_br_target_q;

    logic             misaligned;
    logic             hold_done;
    logic             accept;
    logic [WIDTH-1:0] next_pc;

    assign misaligned = (pc_q[1:0] != 2'b00);
    assign hold_done  = (hold_cnt_q == 4'(HOLD_CYCLES));
    assign accept     = inst_req & inst_addr_ok;
    assign pc         = pc_q;
    assign inst_addr  = pc_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers sample pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: each combinational process assigns a default to every output first,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A flush in the same cycle replaces the bad pc before it is
                // ever reported as an error state.
                if (misaligned && !flush) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (flush) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    always_comb begin
        inst_req = 1'b0;
        addr_err = 1'b0;
        case (state_q)
            ST_RUN: begin
                addr_err = misaligned;
                // An in-flight request ignores stall: it must stay raised,
                // with a stable address, until memory accepts it.
                inst_req = ~misaligned & (req_busy_q | ~stall);
            end
            ST_ERR: begin
                addr_err = 1'b1;
            end
            default: begin
                inst_req = 1'b0;
                addr_err = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next fetch address. Parked flush, then live flush, then parked branch,
    // then live branch, then sequential.
    // -------------------------------------------------------------------------
    always_comb begin
        next_pc = pc_q + WIDTH'(INC);
        if (pend_flush_q) begin
            next_pc = pend_flush_pc_q;
        end else if (flush) begin
            next_pc = flush_pc;
        end else if (pend_br_q) begin
            next_pc = pend_br_target_q;
        end else if (br_taken) begin
            next_pc = br_target;
        end
    end

    // -------------------------------------------------------------------------
    // pc, hold counter, handshake and pending-redirect control
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            hold_cnt_q   <= 4'd0;
            req_busy_q   <= 1'b0;
            pend_flush_q <= 1'b0;
            pend_br_q    <= 1'b0;
        end else begin
            req_busy_q <= 1'b0;
            case (state_q)
                ST_HOLD: begin
                    // Redirects are ignored until the first request goes out.
                    if (!hold_done) begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end

                ST_RUN: begin
                    if (misaligned) begin
                        // Nothing can be outstanding or parked here: a parked
                        // redirect is consumed at the accept that set this pc.
                        if (flush) begin
                            pc_q <= flush_pc;
                        end
                    end else if (accept) begin
                        pc_q         <= next_pc;
                        pend_flush_q <= 1'b0;
                        pend_br_q    <= 1'b0;
                    end else if (inst_req) begin
                        // Address must stay put, so park any redirect.
                        req_busy_q <= 1'b1;
                        if (flush) begin
                            pend_flush_q <= 1'b1;
                            pend_br_q    <= 1'b0;
                        end else if (br_taken && !pend_flush_q) begin
                            pend_br_q <= 1'b1;
                        end
                    end else if (flush || br_taken) begin
                        // Idle: no parked redirects exist, so next_pc is the
                        // live redirect target.
                        pc_q <= next_pc;
                    end
                end

                ST_ERR: begin
                    if (flush) begin
                        pc_q <= flush_pc;
                    end
                end

                default: begin
                    pc_q <= RESET_VECTOR;
                end
            endcase
        end
    end

    // Redirect targets are only read while their valid bit is set, and the
    // bit is only set in the same cycle the target is loaded.
    // NOTE: these data registers deliberately have no reset; their contents
    // are qualified by the pending flags, which are reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_RUN && !misaligned && inst_req && !inst_addr_ok) begin
            if (flush) begin
                pend_flush_pc_q <= flush_pc;
            end else if (br_taken && !pend_flush_q) begin
                pend_br_target_q <= br_target;
            end
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter and fetch-request generator at the front of the MIPS fetch stage.
- Generalises the plain PC register with:
  - a post-reset hold state and configurable vectors;
  - prioritised redirects (exception flush over branch over sequential);
  - a req/addr_ok fetch handshake that may stall;
  - pending-redirect buffering and misaligned-address detection.

Parameters:
- WIDTH, 32, address width in bits (≥ 3).
- RESET_VECTOR, 32'hbfc00000, first fetch address after reset.
- INC, 4, sequential increment in bytes.
- HOLD_CYCLES, 1, cycles spent in HOLD after reset deasserts before the first request (1..15).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  pipeline stall; blocks a new request from issuing but does not retract one in flight.
- flush  in  1  exception/ERET redirect, highest priority.
- flush_pc  in  WIDTH  flush target.
- br_taken  in  1  branch/jump redirect.
- br_target  in  WIDTH  branch target.
- inst_req  out  1  fetch request valid.
- inst_addr  out  WIDTH  fetch address (equals pc).
- inst_addr_ok  in  1  memory accepted the request this cycle.
- pc  out  WIDTH  current PC.
- addr_err  out  1  pc misaligned; fetch suppressed.

Behaviour:
- **Reset (while reset=1).**
  - State=HOLD, pc=RESET_VECTOR, hold counter=0.
  - inst_req=0, addr_err=0, pending flags cleared.
- **States:**
  - HOLD: inst_req=0. The counter increments each cycle. After HOLD_CYCLES cycles with reset=0, go to RUN.
    - flush/br_taken in HOLD are ignored.
  - RUN: inst_req = ~stall & ~addr_err.
    - Exception: once inst_req is high and not yet accepted, it stays high and inst_addr stays stable until inst_addr_ok, regardless of stall.
  - ERR: entered when pc[1:0]≠0.
    - addr_err=1, inst_req=0.
    - Leaves only on flush: pc<=flush_pc, go to RUN.
- **Handshake.**
  - Accept = inst_req & inst_addr_ok.
  - On accept, pc advances to next_pc.
  - Without accept, pc holds unless a redirect is legal (see below).
- **next_pc priority:** pend_flush target > flush_pc > pend_br target > br_target > pc+INC.
  - Arithmetic is modulo 2^WIDTH; pc=all-ones-3 wraps to 0.
- **Redirect with no request outstanding** (inst_req=0 because of stall or idle): pc <= redirect target next cycle, directly.
- **Redirect while a request is outstanding and unaccepted:**
  - Latch into pending registers: pend_flush/pend_flush_pc, or pend_br/pend_br_target.
  - Applied at the accept cycle; the pending bit clears that cycle.
- **Redirect conflicts.**
  - A later flush overwrites a pending branch: pend_br is cleared.
  - A branch arriving while pend_flush=1 is dropped.
  - A new flush overwrites pend_flush_pc.
- **Simultaneous events.**
  - flush & br_taken in the same cycle: the flush wins and the branch is discarded.
  - Redirect in the accept cycle: it is used as next_pc directly, not latched.
- **addr_err.** Evaluated combinationally from pc in RUN; the ERR transition registers on the next edge.
  - A misaligned flush_pc re-enters ERR.
- **Mid-operation reset.** reset overrides everything on the next edge: pending redirects are lost and the outstanding request is abandoned.
- **Latency.**
  - First inst_req is asserted HOLD_CYCLES+1 edges after reset falls.
  - Redirect-to-address is 1 cycle when idle or accepted; otherwise it waits for the accept.

Test Plan:
- **Reset/hold.** reset high 3 cycles, then low, addr_ok=1 always (HOLD_CYCLES=1) → inst_req first high 2 edges after release with inst_addr=bfc00000; next accepts give bfc00004, bfc00008.
- **Backpressure.** Request at bfc00010, addr_ok=0 for 4 cycles with stall toggling → inst_addr stays bfc00010 and inst_req stays 1; on addr_ok=1 pc becomes bfc00014.
- **Pending branch then flush.** br_taken to 80001000 while stalled-unaccepted, then flush to bfc00380 two cycles later, then accept → pc=bfc00380, pend_br cleared, next fetch bfc00380.
- **Simultaneous.** flush (bfc00380) and br_taken (80002000) in an accept cycle → pc=bfc00380.
- **Misalignment.** br_target=80000002 → next cycle addr_err=1, inst_req=0, stays until flush to bfc00380; then addr_err=0 and fetch resumes.
- **Wrap and reset mid-op.** pc=fffffffc accepted → pc=00000000. Assert reset with a pending branch → pc=bfc00000, HOLD, pending cleared.
